// File: rtl/apb_fifo_bridge_if.sv
// APB3 bus bundle between the system bus master and the I2C FIFO bridge slave.
interface apb_fifo_bridge_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8
);
   logic                  PSELx;
   logic                  PENABLE;
   logic                  PWRITE;
   logic [ADDR_WIDTH-1:0] PADDR;
   logic [DATA_WIDTH-1:0] PWDATA;
   logic                  PREADY;
   logic [DATA_WIDTH-1:0] PRDATA;
   logic                  PSLVERR;

   modport master (output PSELx, PENABLE, PWRITE, PADDR, PWDATA,
                   input  PREADY, PRDATA, PSLVERR);
   modport slave  (input  PSELx, PENABLE, PWRITE, PADDR, PWDATA,
                   output PREADY, PRDATA, PSLVERR);
endinterface

// File: rtl/apb_fifo_bridge.sv
// APB3 slave fronting the I2C core TX/RX FIFOs and control registers, with
// wait states on FIFO full/empty and a bounded wait that ends in PSLVERR.
module apb_fifo_bridge #(
   parameter int DATA_WIDTH   = 8,
   parameter int ADDR_WIDTH   = 8,
   parameter int WAIT_TIMEOUT = 15
) (
   input  logic                  PCLK,
   input  logic                  PRESET,
   apb_fifo_bridge_if.slave      apb,
   input  logic [DATA_WIDTH-1:0] APB_RX,
   input  logic                  WRITE_FULL,
   input  logic                  READ_EMPTY,
   output logic                  W_ENA,
   output logic                  R_ENA,
   output logic [DATA_WIDTH-1:0] APB_TX,
   output logic [DATA_WIDTH-1:0] CTRL,
   output logic [6:0]            SLV_ADDR
);
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

   localparam logic [7:0] TO = 8'(WAIT_TIMEOUT);

   state_e                state_q, state_d, phase;
   logic [7:0]            wait_cnt_q, wait_cnt_d;
   logic [DATA_WIDTH-1:0] ctrl_q, ctrl_d;
   logic [6:0]            slv_q, slv_d;
   logic                  sticky_q, sticky_d;

   logic       addr_ok, blocked, timeout, done, bad, err, wr_ok, rd_ok;
   logic [2:0] rsel;

   always_comb begin
      // phase is the bus phase of the current cycle; state_q is the phase of
      // the previous one, reset to IDLE after every completion.
      phase = IDLE;
      unique case (state_q)
         IDLE:    if (apb.PSELx && !apb.PENABLE) phase = SETUP;
         SETUP,
         ACCESS:  if (apb.PSELx && apb.PENABLE) phase = ACCESS;
                  else if (apb.PSELx) phase = SETUP;
         default: phase = IDLE;
      endcase

      rsel    = apb.PADDR[2:0];
      addr_ok = (apb.PADDR >> 3) == '0;
      bad     = !addr_ok || rsel > 3'd4 ||
                (rsel == 3'd0 && !apb.PWRITE) || (rsel == 3'd1 && apb.PWRITE);
      blocked = phase == ACCESS && !bad &&
                ((rsel == 3'd0 && WRITE_FULL) || (rsel == 3'd1 && READ_EMPTY));
      timeout = blocked && wait_cnt_q == TO;
      done    = phase == ACCESS && (!blocked || timeout);
      err     = done && (bad || timeout);
      wr_ok   = done && !err && apb.PWRITE;
      rd_ok   = done && !err && !apb.PWRITE;

      apb.PREADY  = done;
      apb.PSLVERR = err;
      W_ENA       = wr_ok && rsel == 3'd0;
      R_ENA       = rd_ok && rsel == 3'd1;
      APB_TX      = apb.PWDATA;
      CTRL        = ctrl_q;
      SLV_ADDR    = slv_q;

      apb.PRDATA = '0;
      if (rd_ok) begin
         unique case (rsel)
            3'd1:    apb.PRDATA = APB_RX;
            3'd2:    apb.PRDATA = ctrl_q;
            3'd3:    apb.PRDATA = {{(DATA_WIDTH-3){1'b0}}, sticky_q, READ_EMPTY, WRITE_FULL};
            3'd4:    apb.PRDATA = {{(DATA_WIDTH-7){1'b0}}, slv_q};
            default: apb.PRDATA = '0;
         endcase
      end

      state_d    = done ? IDLE : phase;
      wait_cnt_d = (blocked && !timeout) ? wait_cnt_q + 8'd1 : '0;
      ctrl_d     = (wr_ok && rsel == 3'd2) ? apb.PWDATA : ctrl_q;
      slv_d      = (wr_ok && rsel == 3'd4) ? apb.PWDATA[6:0] : slv_q;
      sticky_d   = sticky_q;
      if (wr_ok && rsel == 3'd3 && apb.PWDATA[2]) sticky_d = 1'b0;
      if (timeout) sticky_d = 1'b1;
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state_q    <= IDLE;
         wait_cnt_q <= '0;
         ctrl_q     <= '0;
         slv_q      <= '0;
         sticky_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         ctrl_q     <= ctrl_d;
         slv_q      <= slv_d;
         sticky_q   <= sticky_d;
      end
   end
endmodule

// File: tb/tb_apb_fifo_bridge.sv
// Directed plus randomized APB transfers against a transaction-level model
// of the bridge's register map, wait and timeout rules.
module tb_apb_fifo_bridge;
   localparam int TO = 15;

   logic       PCLK = 1'b0;
   logic       PRESET;
   logic [7:0] APB_RX;
   logic       WRITE_FULL, READ_EMPTY;
   logic       W_ENA, R_ENA;
   logic [7:0] APB_TX, CTRL;
   logic [6:0] SLV_ADDR;

   apb_fifo_bridge_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) apb ();

   apb_fifo_bridge #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .WAIT_TIMEOUT(TO)) dut (
      .PCLK(PCLK), .PRESET(PRESET), .apb(apb.slave), .APB_RX(APB_RX),
      .WRITE_FULL(WRITE_FULL), .READ_EMPTY(READ_EMPTY), .W_ENA(W_ENA),
      .R_ENA(R_ENA), .APB_TX(APB_TX), .CTRL(CTRL), .SLV_ADDR(SLV_ADDR));

   always #5 PCLK = ~PCLK;

   int ntests = 0, nfail = 0, cyc = 0;
   always @(posedge PCLK) cyc <= cyc + 1;

   // model state
   logic [7:0] m_ctrl = 8'h00, m_slv = 8'h00, rx_val;
   bit         m_sticky = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      apb.PSELx = 1'b0; apb.PENABLE = 1'b0;
      @(negedge PCLK);
      chk("idle_pready", 32'(apb.PREADY), 32'd0);
      chk("idle_prdata", 32'(apb.PRDATA), 32'd0);
      @(posedge PCLK); #1;
   endtask

   // Runs one APB transfer; the FIFO flags are held high for the first fc/ec
   // access cycles respectively.
   task automatic xfer(input bit wr, input logic [7:0] a, input logic [7:0] wd,
                       input int fc, input int ec, output bit err, output int nwait,
                       output logic [7:0] rd, output int nw, output int nr);
      bit done = 1'b0;
      apb.PSELx = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = wr; apb.PADDR = a; apb.PWDATA = wd;
      APB_RX = 8'($urandom); rx_val = APB_RX;
      WRITE_FULL = 1'b0; READ_EMPTY = 1'b0;
      @(negedge PCLK);
      chk("setup_pready", 32'({apb.PREADY, W_ENA, R_ENA}), 32'd0);
      @(posedge PCLK); #1;
      apb.PENABLE = 1'b1;
      nwait = 0; nw = 0; nr = 0; err = 1'b0; rd = '0;
      for (int c = 0; c < 300 && !done; c++) begin
         WRITE_FULL = (c < fc); READ_EMPTY = (c < ec);
         @(negedge PCLK);
         if (W_ENA) begin nw++; chk("apb_tx", 32'(APB_TX), 32'(wd)); end
         if (R_ENA) nr++;
         if (apb.PREADY) begin
            done = 1'b1; err = apb.PSLVERR; rd = apb.PRDATA;
         end else nwait++;
         @(posedge PCLK); #1;
      end
      WRITE_FULL = 1'b0; READ_EMPTY = 1'b0;
      if (!done) chk("cycle_bound", 32'(done), 32'd1);
   endtask

   // Expected outcome of one transfer, derived from the register map rules.
   task automatic model(input bit wr, input logic [7:0] a, input logic [7:0] wd,
                        input int fc, input int ec, output bit e_err, output int e_wait,
                        output logic [7:0] e_rd, output int e_w, output int e_r);
      int blk = 0;
      bit bad;
      bad = (a > 8'd4) || (a == 8'd0 && !wr) || (a == 8'd1 && wr);
      if (!bad && a == 8'd0) blk = fc;
      if (!bad && a == 8'd1) blk = ec;
      e_wait = (blk > TO) ? TO : blk;
      e_err  = bad || blk > TO;
      e_rd = '0; e_w = 0; e_r = 0;
      if (blk > TO) m_sticky = 1'b1;
      else if (!bad) begin
         if (wr) begin
            case (a)
               8'd0: e_w = 1;
               8'd2: m_ctrl = wd;
               8'd3: if (wd[2]) m_sticky = 1'b0;
               8'd4: m_slv = wd & 8'h7f;
               default: ;
            endcase
         end else begin
            case (a)
               8'd1: begin e_r = 1; e_rd = rx_val; end
               8'd2: e_rd = m_ctrl;
               8'd3: e_rd = {5'b0, m_sticky, ec > 0, fc > 0};
               8'd4: e_rd = m_slv;
               default: ;
            endcase
         end
      end
   endtask

   task automatic op(input bit wr, input logic [7:0] a, input logic [7:0] wd,
                     input int fc, input int ec);
      bit err, e_err;
      int nwait, nw, nr, e_wait, e_w, e_r;
      logic [7:0] rd, e_rd;
      xfer(wr, a, wd, fc, ec, err, nwait, rd, nw, nr);
      model(wr, a, wd, fc, ec, e_err, e_wait, e_rd, e_w, e_r);
      chk("pslverr", 32'(err), 32'(e_err));
      chk("wait_cycles", 32'(nwait), 32'(e_wait));
      chk("prdata", 32'(rd), 32'(e_rd));
      chk("w_ena_pulses", 32'(nw), 32'(e_w));
      chk("r_ena_pulses", 32'(nr), 32'(e_r));
      chk("ctrl_port", 32'(CTRL), 32'(m_ctrl));
      chk("slv_addr_port", 32'(SLV_ADDR), 32'(m_slv));
   endtask

   initial begin
      int c0;
      PRESET = 1'b1; APB_RX = '0; WRITE_FULL = 1'b0; READ_EMPTY = 1'b0;
      apb.PSELx = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0; apb.PADDR = '0; apb.PWDATA = '0;
      repeat (2) @(posedge PCLK);
      @(negedge PCLK);
      chk("rst_outputs", 32'({apb.PREADY, apb.PSLVERR, W_ENA, R_ENA}), 32'd0);
      chk("rst_regs", 32'({apb.PRDATA, CTRL, 1'b0, SLV_ADDR}), 32'd0);
      @(posedge PCLK); #1;
      PRESET = 1'b0;
      idle();

      // TX write, zero wait
      op(1'b1, 8'h00, 8'h55, 0, 0);
      idle();
      // TX full for 3 cycles, then push
      op(1'b1, 8'h00, 8'h3c, 3, 0);
      // RX pop, zero wait and with empty for 2 cycles
      op(1'b0, 8'h01, 8'h00, 0, 0);
      op(1'b0, 8'h01, 8'h00, 0, 2);
      // boundary: 15 blocked cycles still completes, 16 times out
      op(1'b1, 8'h00, 8'h11, TO, 0);
      op(1'b0, 8'h01, 8'h00, 0, 100);
      op(1'b0, 8'h03, 8'h00, 0, 0);
      op(1'b0, 8'h03, 8'h00, 1, 1);
      op(1'b1, 8'h03, 8'h04, 0, 0);
      op(1'b0, 8'h03, 8'h00, 0, 0);
      op(1'b1, 8'h00, 8'h22, TO + 1, 0);
      // register map and error decode
      op(1'b1, 8'h02, 8'hA5, 0, 0);
      op(1'b1, 8'h04, 8'hFF, 0, 0);
      op(1'b0, 8'h02, 8'h00, 0, 0);
      op(1'b0, 8'h04, 8'h00, 0, 0);
      op(1'b1, 8'h06, 8'h00, 0, 0);
      op(1'b1, 8'h0A, 8'h00, 0, 0);
      op(1'b0, 8'h00, 8'h00, 0, 0);
      op(1'b1, 8'h01, 8'h77, 0, 0);
      op(1'b0, 8'h02, 8'h00, 0, 0);
      idle();

      // back-to-back TX writes: 2 cycles each, no idle between
      c0 = cyc;
      op(1'b1, 8'h00, 8'hC3, 0, 0);
      op(1'b1, 8'h00, 8'h5A, 0, 0);
      chk("b2b_cycles", 32'(cyc - c0), 32'd4);
      idle();

      for (int i = 0; i < 60; i++) begin
         bit wr;
         logic [7:0] a;
         int fc, ec, r;
         wr = 1'($urandom);
         a  = 8'($urandom_range(0, 8));
         if (a == 8'd8) a = 8'($urandom_range(8, 255));
         r  = $urandom_range(0, 9);
         fc = (r == 6 || r == 7) ? $urandom_range(1, 5) : (r == 8) ? $urandom_range(TO, TO + 2) : 0;
         r  = $urandom_range(0, 9);
         ec = (r == 6 || r == 7) ? $urandom_range(1, 5) : (r == 8) ? $urandom_range(TO, TO + 2) : 0;
         op(wr, a, 8'($urandom), fc, ec);
         if ($urandom_range(0, 1) == 0) idle();
      end

      // reset in the middle of a waiting TX write
      apb.PSELx = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1; apb.PADDR = 8'h00; apb.PWDATA = 8'h99;
      @(posedge PCLK); #1;
      apb.PENABLE = 1'b1; WRITE_FULL = 1'b1;
      @(posedge PCLK); #1;
      WRITE_FULL = 1'b0; PRESET = 1'b1;
      m_ctrl = '0; m_slv = '0; m_sticky = 1'b0;
      @(negedge PCLK);
      chk("midrst_outputs", 32'({apb.PREADY, apb.PSLVERR, W_ENA, R_ENA}), 32'd0);
      chk("midrst_regs", 32'({apb.PRDATA, CTRL, 1'b0, SLV_ADDR}), 32'd0);
      @(posedge PCLK); #1;
      PRESET = 1'b0;
      @(negedge PCLK);
      chk("enable_no_setup", 32'({apb.PREADY, W_ENA, R_ENA}), 32'd0);
      @(posedge PCLK); #1;
      idle();
      op(1'b0, 8'h03, 8'h00, 0, 0);
      op(1'b1, 8'h00, 8'h66, 0, 0);
      idle();

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end
endmodule
